// File: rtl/vedic_pp_accum_seq.sv
// ---------------------------------------------------------------------------
// vedic_pp_accum_seq
//   Sequential partial-product accumulator for an N x N Vedic multiplier.
//   Four (N/2)x(N/2) partial products are combined into the 2N-bit product.
//   One S-bit ripple slice, built from full_adder cells with a registered
//   carry, performs every addition. Each pass takes K = 2N/S slice steps.
//     pass ADD1 : acc = {q3,q0} + (q1 << N/2)
//     pass ADD2 : acc = acc     + (q2 << N/2)
//
// Ports
//   clk      in   1   clock, rising edge
//   rst      in   1   synchronous reset, active-high
//   start    in   1   request; sampled only in IDLE
//   q0..q3   in   N   partial products aL*bL, aH*bL, aL*bH, aH*bH
//   busy     out  1   high during ADD1/ADD2
//   done     out  1   one-cycle pulse; product/err valid
//   product  out  2N  result; held until the next done
//   err      out  1   a pass overflowed its top slice
// ---------------------------------------------------------------------------

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module vedic_pp_accum_seq #(
    parameter int N = 8,
    parameter int S = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   q0,
    input  logic [N-1:0]   q1,
    input  logic [N-1:0]   q2,
    input  logic [N-1:0]   q3,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic           err
);
    localparam int W  = 2 * N;
    localparam int K  = W / S;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, ADD1, ADD2, DONE} state_t;

    state_t         state_q;
    logic [W-1:0]   acc_q, op1_q, op2_q, product_q;
    logic [IW-1:0]  idx_q;
    logic           carry_q, err_int_q, err_q, busy_q, done_q;

    // Operand and accumulator slices currently under the adder
    logic [S-1:0]   acc_sl, op_sl, sum_sl;
    logic [S:0]     rc;
    logic [W-1:0]   acc_d;
    logic           last_slice;

    always_comb begin
        acc_sl = acc_q[idx_q*S +: S];
        op_sl  = (state_q == ADD2) ? op2_q[idx_q*S +: S] : op1_q[idx_q*S +: S];
    end

    assign rc[0] = carry_q;

    for (genvar g = 0; g < S; g++) begin : g_fa
        full_adder u_fa (
            .a_i (acc_sl[g]),
            .b_i (op_sl[g]),
            .c_i (rc[g]),
            .s_o (sum_sl[g]),
            .c_o (rc[g+1])
        );
    end

    always_comb begin
        acc_d               = acc_q;
        acc_d[idx_q*S +: S] = sum_sl;
    end

    assign last_slice = (idx_q == IW'(K - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            err_int_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q     <= {q3, q0};
                        op1_q     <= {{N{1'b0}}, q1} << (N / 2);
                        op2_q     <= {{N{1'b0}}, q2} << (N / 2);
                        idx_q     <= '0;
                        carry_q   <= 1'b0;
                        err_int_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ADD1;
                    end
                end
                ADD1, ADD2: begin
                    acc_q <= acc_d;
                    if (last_slice) begin
                        // Top-slice carry leaves the 2N-bit result; it only
                        // marks inconsistent partial products.
                        idx_q     <= '0;
                        carry_q   <= 1'b0;
                        err_int_q <= err_int_q | rc[S];
                        if (state_q == ADD1) begin
                            state_q <= ADD2;
                        end else begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            product_q <= acc_d;
                            err_q     <= err_int_q | rc[S];
                        end
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        carry_q <= rc[S];
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign err     = err_q;

endmodule
